mor1kx_wb_cappuccino: RTL and testbench
=======================================

MOR1KX_WB_CAPPUCCINO -- requirements
Module: mor1kx_wb_cappuccino

Interface
REQ-001 SHALL have parameter OPTION_OPERAND_WIDTH, default 32, datapath width; load extension is defined for 32 only.
REQ-002 SHALL have parameter OPTION_RF_ADDR_WIDTH, default 5, GPR address width.
REQ-003 SHALL have one clock and a synchronous, active-low reset: ports clk and rst.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-low reset, sampled on clk.
REQ-006 padv_wb_i  in  1  advance the instruction from ctrl into wb.
REQ-007 pipeline_flush_i  in  1  kill the ctrl and wb instructions.
REQ-008 ctrl_rf_wb_i  in  1  the ctrl instruction writes a GPR.
REQ-009 ctrl_rfd_adr_i  in  OPTION_RF_ADDR_WIDTH  ctrl destination GPR.
REQ-010 ctrl_alu_result_i  in  OPTION_OPERAND_WIDTH  ctrl non-load result.
REQ-011 ctrl_op_lsu_load_i  in  1  the ctrl instruction is a load.
REQ-012 ctrl_lsu_length_i  in  2  load size: 00 byte, 01 half, 10 word.
REQ-013 ctrl_lsu_zext_i  in  1  1 = zero-extend, 0 = sign-extend.
REQ-014 ctrl_lsu_adr_i  in  2  low bits of the load address.
REQ-015 lsu_valid_i  in  1  single-cycle pulse: lsu_dat_i is valid.
REQ-016 lsu_dat_i  in  OPTION_OPERAND_WIDTH  raw big-endian bus word.
REQ-017 lsu_except_i  in  1  load bus error, qualified by lsu_valid_i.
REQ-018 wb_rf_wb_o  out  1  register-file write enable.
REQ-019 wb_rfd_adr_o  out  OPTION_RF_ADDR_WIDTH  write address.
REQ-020 result_o  out  OPTION_OPERAND_WIDTH  write data and bypass value.
REQ-021 wb_stall_o  out  1  ctrl load still waiting for data; holds padv_wb_i low.

Function
REQ-022 SHALL implement an FSM with states IDLE, WAIT and HOLD.
- IDLE -> HOLD: ctrl_op_lsu_load_i & lsu_valid_i.
- IDLE -> WAIT: ctrl_op_lsu_load_i & !lsu_valid_i.
- WAIT -> HOLD: lsu_valid_i.
- HOLD -> IDLE: padv_wb_i.
REQ-023 SHALL capture lsu_dat_i and lsu_except_i into hold registers on every lsu_valid_i taken in IDLE or WAIT.
REQ-024 wb_stall_o SHALL be combinational: ctrl_op_lsu_load_i & (state != HOLD) & !lsu_valid_i.
REQ-025 The load data source SHALL be lsu_dat_i when lsu_valid_i is high in the padv_wb_i cycle, otherwise the hold register.
REQ-026 On padv_wb_i without flush, the next cycle SHALL have:
- wb_rfd_adr_o = ctrl_rfd_adr_i;
- result_o = extended load data if ctrl_op_lsu_load_i, else ctrl_alu_result_i;
- wb_rf_wb_o = ctrl_rf_wb_i & !(load & captured except).
REQ-027 wb_rf_wb_o SHALL be high for exactly one cycle per advanced instruction; it SHALL be 0 in any cycle not following padv_wb_i.
REQ-028 result_o and wb_rfd_adr_o SHALL hold their values until the next padv_wb_i.
REQ-029 Byte load SHALL select lane adr 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
REQ-030 Half load SHALL select adr[1] 0 -> [31:16], 1 -> [15:0]; word loads SHALL ignore the address.
REQ-031 Byte and half results SHALL be extended to 32 bits using ctrl_lsu_zext_i.
REQ-032 pipeline_flush_i SHALL have priority over padv_wb_i in the same cycle.
- Next cycle: FSM = IDLE, wb_rf_wb_o = 0, hold registers cleared.
- result_o and wb_rfd_adr_o are unchanged.

Reset
REQ-033 With rst low at a clock edge, the block SHALL enter:
- FSM IDLE;
- wb_rf_wb_o 0, wb_rfd_adr_o 0, result_o 0;
- hold data 0, hold except 0.
REQ-034 Reset SHALL override flush and advance, including mid-WAIT or mid-HOLD; the pending load is discarded.

Configuration
REQ-035 Macro MOR1KX_WB_LOAD_EXT_EN defined: the lane select and extension of REQ-029..031 SHALL be compiled in.
REQ-036 Macro undefined: load result SHALL be the load data source unmodified, and ctrl_lsu_length_i, ctrl_lsu_zext_i and ctrl_lsu_adr_i SHALL be unused.

Verification
REQ-037 ALU op, rf_wb=1, rfd=5, result 0x12345678, padv_wb_i pulse -> next cycle wb_rf_wb_o=1, wb_rfd_adr_o=5, result_o=0x12345678; following cycle wb_rf_wb_o=0.
REQ-038 Byte load, adr=1, sext, lsu_valid_i one cycle later with 0x00800000 -> wb_stall_o=1 for exactly 1 cycle; after advance result_o=0xFFFFFF80.
REQ-039 Half load, adr=2, zext, data 0x0000ABCD held 3 cycles in HOLD before padv_wb_i -> result_o=0x0000ABCD, wb_rf_wb_o=1 once.
REQ-040 Word load with lsu_except_i=1 -> after advance wb_rf_wb_o=0, FSM IDLE.
REQ-041 pipeline_flush_i and padv_wb_i in the same cycle while in WAIT -> wb_rf_wb_o=0, FSM IDLE, wb_stall_o follows REQ-024 with fresh inputs.
REQ-042 rst low for one cycle while in HOLD -> all outputs 0, FSM IDLE; build with and without MOR1KX_WB_LOAD_EXT_EN (byte load 0x11223344 adr 0 -> 0x00000011 vs 0x11223344).

Source files
------------

// File: rtl/mor1kx_wb_cappuccino.sv
// Write-back stage of the cappuccino pipeline: registers the ctrl result and waits for, captures and formats load data.
// Define MOR1KX_WB_LOAD_EXT_EN to compile in byte/half lane selection with sign/zero extension.
module mor1kx_wb_cappuccino #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            padv_wb_i,
  input  logic                            pipeline_flush_i,
  input  logic                            ctrl_rf_wb_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] ctrl_rfd_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_alu_result_i,
  input  logic                            ctrl_op_lsu_load_i,
  input  logic [1:0]                      ctrl_lsu_length_i,
  input  logic                            ctrl_lsu_zext_i,
  input  logic [1:0]                      ctrl_lsu_adr_i,
  input  logic                            lsu_valid_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] lsu_dat_i,
  input  logic                            lsu_except_i,
  output logic                            wb_rf_wb_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] result_o,
  output logic                            wb_stall_o
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t                          state, state_next;
  logic [OPTION_OPERAND_WIDTH-1:0] hold_dat;
  logic                            hold_except;
  logic [OPTION_OPERAND_WIDTH-1:0] load_src;
  logic                            load_except;
  logic [OPTION_OPERAND_WIDTH-1:0] load_result;

  assign wb_stall_o  = ctrl_op_lsu_load_i & (state != HOLD) & ~lsu_valid_i;
  assign load_src    = lsu_valid_i ? lsu_dat_i : hold_dat;
  assign load_except = lsu_valid_i ? lsu_except_i : hold_except;

  // NOTE: state_next gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ctrl_op_lsu_load_i) state_next = lsu_valid_i ? HOLD : WAIT;
      WAIT:    if (lsu_valid_i) state_next = HOLD;
      HOLD:    state_next = HOLD;
      default: state_next = IDLE;
    endcase
    // Any advance retires the ctrl instruction, so a captured load never outlives it.
    if (padv_wb_i || pipeline_flush_i) state_next = IDLE;
  end

`ifdef MOR1KX_WB_LOAD_EXT_EN
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Big-endian lanes: address 0 is the most significant byte of the bus word.
  always_comb begin
    case (ctrl_lsu_adr_i)
      2'd0:    load_byte = load_src[31:24];
      2'd1:    load_byte = load_src[23:16];
      2'd2:    load_byte = load_src[15:8];
      default: load_byte = load_src[7:0];
    endcase
    load_half = ctrl_lsu_adr_i[1] ? load_src[15:0] : load_src[31:16];
    case (ctrl_lsu_length_i)
      2'b00:   load_result = {{24{~ctrl_lsu_zext_i & load_byte[7]}}, load_byte};
      2'b01:   load_result = {{16{~ctrl_lsu_zext_i & load_half[15]}}, load_half};
      default: load_result = load_src;
    endcase
  end
`else
  logic unused_lsu_fmt;

  assign load_result    = load_src;
  assign unused_lsu_fmt = ^{ctrl_lsu_length_i, ctrl_lsu_zext_i, ctrl_lsu_adr_i};
`endif

  // NOTE: all state here is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      hold_dat     <= '0;
      hold_except  <= 1'b0;
      wb_rf_wb_o   <= 1'b0;
      wb_rfd_adr_o <= '0;
      result_o     <= '0;
    end else begin
      state      <= state_next;
      wb_rf_wb_o <= 1'b0;
      if (pipeline_flush_i) begin
        hold_dat    <= '0;
        hold_except <= 1'b0;
      end else begin
        if (lsu_valid_i && state != HOLD) begin
          hold_dat    <= lsu_dat_i;
          hold_except <= lsu_except_i;
        end
        if (padv_wb_i) begin
          wb_rf_wb_o   <= ctrl_rf_wb_i & ~(ctrl_op_lsu_load_i & load_except);
          wb_rfd_adr_o <= ctrl_rfd_adr_i;
          result_o     <= ctrl_op_lsu_load_i ? load_result : ctrl_alu_result_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_mor1kx_wb_cappuccino.sv
// Scoreboard bench for mor1kx_wb_cappuccino: directed scenarios then random traffic against a transaction-level model.
// Honours MOR1KX_WB_LOAD_EXT_EN in the model so either build can be checked.
module tb_mor1kx_wb_cappuccino;
  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          padv, flush, rf_wb, load, zext, valid, exc;
  logic [AW-1:0] rfd;
  logic [W-1:0]  alu, dat;
  logic [1:0]    len, ladr;
  logic          wb_rf_wb_o, wb_stall_o;
  logic [AW-1:0] wb_rfd_adr_o;
  logic [W-1:0]  result_o;

  always #5 clk = ~clk;

  mor1kx_wb_cappuccino #(.OPTION_OPERAND_WIDTH(W), .OPTION_RF_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .padv_wb_i(padv), .pipeline_flush_i(flush),
    .ctrl_rf_wb_i(rf_wb), .ctrl_rfd_adr_i(rfd), .ctrl_alu_result_i(alu),
    .ctrl_op_lsu_load_i(load), .ctrl_lsu_length_i(len), .ctrl_lsu_zext_i(zext),
    .ctrl_lsu_adr_i(ladr), .lsu_valid_i(valid), .lsu_dat_i(dat), .lsu_except_i(exc),
    .wb_rf_wb_o(wb_rf_wb_o), .wb_rfd_adr_o(wb_rfd_adr_o), .result_o(result_o),
    .wb_stall_o(wb_stall_o)
  );

  typedef struct packed {
    logic          rf_wb;
    logic [AW-1:0] adr;
    logic [W-1:0]  res;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: whether the current load already has its data, the latched data, and the architectural outputs.
  logic          m_have = 1'b0;
  logic [W-1:0]  m_dat  = '0;
  logic          m_exc  = 1'b0;
  logic          m_rf_wb = 1'b0;
  logic [AW-1:0] m_adr  = '0;
  logic [W-1:0]  m_res  = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, req);
    end
  endtask

`ifdef MOR1KX_WB_LOAD_EXT_EN
  function automatic logic [W-1:0] model_load(input logic [W-1:0] d, input logic [1:0] l,
                                              input logic z, input logic [1:0] a);
    longint unsigned v;
    int              bits;
    int              ai = int'(a);
    if (l == 2'b00) begin
      v = (longint'(d) >> (8 * (3 - ai))) & 64'hFF;
      bits = 8;
    end else if (l == 2'b01) begin
      v = (longint'(d) >> (16 * (1 - ai / 2))) & 64'hFFFF;
      bits = 16;
    end else begin
      return d;
    end
    if (!z && ((v >> (bits - 1)) & 1) == 1) v = v + 64'hFFFF_FFFF_0000_0000 - (64'd1 << bits) + 64'h1_0000_0000;
    return W'(v);
  endfunction
`endif

  // One clock: check the combinational stall, advance the model, and queue what the outputs must show after the edge.
  task automatic cycle();
    logic [W-1:0] src, ld_val;
    logic         src_exc;
    exp_t         e;
    #1;
    check("wb_stall", W'(wb_stall_o), W'(load && !m_have && !valid));
    if (!rst) begin
      {m_have, m_dat, m_exc, m_rf_wb, m_adr, m_res} = '0;
    end else if (flush) begin
      {m_have, m_dat, m_exc, m_rf_wb} = '0;
    end else begin
      src     = valid ? dat : m_dat;
      src_exc = valid ? exc : m_exc;
`ifdef MOR1KX_WB_LOAD_EXT_EN
      ld_val = model_load(src, len, zext, ladr);
`else
      ld_val = src;
`endif
      if (!m_have && valid) begin
        m_dat = dat;
        m_exc = exc;
      end
      if (padv) begin
        m_rf_wb = rf_wb && !(load && src_exc);
        m_adr   = rfd;
        m_res   = load ? ld_val : alu;
        m_have  = 1'b0;
      end else begin
        m_rf_wb = 1'b0;
        if (load && valid) m_have = 1'b1;
      end
    end
    e = '{rf_wb: m_rf_wb, adr: m_adr, res: m_res};
    @(posedge clk);
    #1;
    exp_q.push_back(e);
  endtask

  task automatic set_instr(input logic ld, input logic wb, input logic [AW-1:0] a, input logic [W-1:0] r,
                           input logic [1:0] l, input logic z, input logic [1:0] la);
    load = ld; rf_wb = wb; rfd = a; alu = r; len = l; zext = z; ladr = la;
  endtask

  task automatic quiet();
    rst = 1'b1; padv = 1'b0; flush = 1'b0; valid = 1'b0; exc = 1'b0; dat = '0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wb_rf_wb", W'(wb_rf_wb_o), W'(e.rf_wb));
        check("wb_rfd_adr", W'(wb_rfd_adr_o), W'(e.adr));
        check("result", result_o, e.res);
      end
    end
  end

  initial begin : stimulus
    logic need_new;
    quiet();
    set_instr(1'b0, 1'b0, '0, '0, 2'b10, 1'b0, 2'b00);
    rst = 1'b0;
    cycle(); cycle();
    quiet();

    // ALU result written once
    set_instr(1'b0, 1'b1, 5'd5, 32'h1234_5678, 2'b10, 1'b0, 2'b00);
    padv = 1'b1; cycle();
    padv = 1'b0; set_instr(1'b0, 1'b0, 5'd0, 32'h0, 2'b10, 1'b0, 2'b00); cycle(); cycle();

    // Signed byte load, data one cycle late
    set_instr(1'b1, 1'b1, 5'd7, 32'h0, 2'b00, 1'b0, 2'b01); cycle();
    valid = 1'b1; dat = 32'h0080_0000; cycle();
    quiet(); padv = 1'b1; cycle();
    quiet(); set_instr(1'b0, 1'b0, 5'd0, 32'h0, 2'b10, 1'b0, 2'b00); cycle();

    // Zero-extended half load parked in HOLD for three cycles
    set_instr(1'b1, 1'b1, 5'd9, 32'h0, 2'b01, 1'b1, 2'b10);
    valid = 1'b1; dat = 32'h0000_ABCD; cycle();
    quiet(); cycle(); cycle(); cycle();
    padv = 1'b1; cycle();
    quiet(); set_instr(1'b0, 1'b0, 5'd0, 32'h0, 2'b10, 1'b0, 2'b00); cycle(); cycle();

    // Word load with a bus error suppresses the write
    set_instr(1'b1, 1'b1, 5'd3, 32'h0, 2'b10, 1'b0, 2'b00);
    valid = 1'b1; exc = 1'b1; dat = 32'hCAFE_F00D; cycle();
    quiet(); padv = 1'b1; cycle();
    quiet(); set_instr(1'b1, 1'b1, 5'd4, 32'h0, 2'b10, 1'b0, 2'b00); cycle();

    // Flush and advance together while waiting; the next load must stall again
    flush = 1'b1; padv = 1'b1; cycle();
    quiet(); set_instr(1'b1, 1'b1, 5'd6, 32'h0, 2'b10, 1'b0, 2'b00); cycle();
    flush = 1'b1; cycle();

    // Reset while holding load data, then the byte lane case
    quiet(); set_instr(1'b1, 1'b1, 5'd11, 32'h0, 2'b00, 1'b1, 2'b00);
    valid = 1'b1; dat = 32'h1122_3344; cycle();
    quiet(); rst = 1'b0; cycle();
    quiet(); cycle();
    valid = 1'b1; dat = 32'h1122_3344; padv = 1'b1; cycle();
    quiet(); set_instr(1'b0, 1'b0, 5'd0, 32'h0, 2'b10, 1'b0, 2'b00); cycle();

    need_new = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      if (need_new)
        set_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 31)),
                  W'($urandom), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      rst   = ($urandom_range(0, 63) != 0);
      flush = ($urandom_range(0, 19) == 0);
      valid = load && !m_have && ($urandom_range(0, 2) == 0);
      dat   = W'($urandom);
      exc   = ($urandom_range(0, 7) == 0);
      padv  = !(load && !m_have && !valid) && ($urandom_range(0, 1) == 1);
      need_new = padv || flush || !rst;
      cycle();
    end

    quiet(); set_instr(1'b0, 1'b0, 5'd0, 32'h0, 2'b10, 1'b0, 2'b00);
    cycle(); cycle();
    repeat (3) @(posedge clk);
    check("queue_drained", W'(exp_q.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
